// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep scheduler: steps the DDS tuning word M from f_start to f_stop with a
// programmable dwell per value, in single, sawtooth-repeat or triangle mode.
module dds_sweep_ctrl #(
    parameter int N       = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [N-1:0]       f_start,
    input  logic [N-1:0]       f_stop,
    input  logic [N-1:0]       f_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [N-1:0]       M,
    output logic               step_stb,
    output logic               busy,
    output logic               done,
    output logic               dir_up
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state;
    logic [1:0]         mode_r;
    logic [N-1:0]       org;
    logic [N-1:0]       tgt;
    logic [N-1:0]       step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [DWELL_W-1:0] cnt;

    logic               at_end;
    logic [N-1:0]       step_in;
    logic [DWELL_W-1:0] dwell_in;

    // One step toward the endpoint at N+1 bits; overshoot or wrap saturates to the endpoint.
    function automatic logic [N-1:0] step_clamp(input logic [N-1:0] cur,
                                                 input logic [N-1:0] endpt,
                                                 input logic [N-1:0] stp,
                                                 input logic         up);
        logic [N:0] nxt;
        if (up) begin
            nxt = {1'b0, cur} + {1'b0, stp};
            if (nxt > {1'b0, endpt}) nxt = {1'b0, endpt};
        end else begin
            nxt = {1'b0, cur} - {1'b0, stp};
            if (nxt[N] || nxt < {1'b0, endpt}) nxt = {1'b0, endpt};
        end
        return nxt[N-1:0];
    endfunction

    assign at_end   = (M == tgt);
    assign step_in  = (f_step == '0) ? N'(1) : f_step;
    assign dwell_in = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            M        <= '0;
            step_stb <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dir_up   <= 1'b1;
            cnt      <= '0;
            mode_r   <= '0;
            org      <= '0;
            tgt      <= '0;
            step_r   <= '0;
            dwell_r  <= '0;
        end else begin
            step_stb <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        mode_r   <= mode;
                        org      <= f_start;
                        tgt      <= f_stop;
                        step_r   <= step_in;
                        dwell_r  <= dwell_in;
                        cnt      <= dwell_in;
                        M        <= f_start;
                        step_stb <= 1'b1;
                        busy     <= 1'b1;
                        dir_up   <= (f_start <= f_stop);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == DWELL_W'(1)) begin
                        cnt <= dwell_r;
                        if (!at_end) begin
                            M        <= step_clamp(M, tgt, step_r, dir_up);
                            step_stb <= 1'b1;
                        end else if (mode_r == 2'b01) begin
                            M        <= org;
                            step_stb <= 1'b1;
                        end else if (mode_r == 2'b10) begin
                            // Turn at the apex: step straight away so the endpoint is not dwelt twice.
                            M        <= step_clamp(M, org, step_r, !dir_up);
                            org      <= tgt;
                            tgt      <= org;
                            dir_up   <= !dir_up;
                            step_stb <= 1'b1;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= FIN;
                        end
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: single, clamp, sawtooth, triangle, control and reset cases.
module tb_dds_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] f_start;
    logic [15:0] f_stop;
    logic [15:0] f_step;
    logic [15:0] dwell;
    logic [15:0] M;
    logic        step_stb;
    logic        busy;
    logic        done;
    logic        dir_up;

    int n_cmp = 0;
    int n_err = 0;

    dds_sweep_ctrl #(.N(16), .DWELL_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .f_start  (f_start),
        .f_stop   (f_stop),
        .f_step   (f_step),
        .dwell    (dwell),
        .M        (M),
        .step_stb (step_stb),
        .busy     (busy),
        .done     (done),
        .dir_up   (dir_up)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [1:0] md, input logic [15:0] fs, input logic [15:0] fe,
                               input logic [15:0] st, input logic [15:0] dw);
        mode    = md;
        f_start = fs;
        f_stop  = fe;
        f_step  = st;
        dwell   = dw;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    // Checks n cycles of one M value; the first cycle must carry step_stb.
    task automatic expect_m(input string tag, input logic [15:0] v, input int n, input logic d);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_M"}, 32'(M), 32'(v));
            chk({tag, "_stb"}, 32'(step_stb), 32'(i == 0));
            chk({tag, "_dir"}, 32'(dir_up), 32'(d));
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            tick();
        end
    endtask

    task automatic expect_done(input string tag, input logic [15:0] v);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_Mend"}, 32'(M), 32'(v));
        tick();
        chk({tag, "_done_low"}, 32'(done), 32'd0);
        chk({tag, "_Mhold"}, 32'(M), 32'(v));
    endtask

    initial begin
        rst     = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        mode    = 2'b00;
        f_start = '0;
        f_stop  = '0;
        f_step  = '0;
        dwell   = '0;
        #12;
        chk("rst_M", 32'(M), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stb", 32'(step_stb), 32'd0);
        chk("rst_dir", 32'(dir_up), 32'd1);
        rst = 1'b1;
        tick();

        // single up sweep
        start_sweep(2'b00, 16'd100, 16'd130, 16'd10, 16'd3);
        expect_m("t1_100", 16'd100, 3, 1'b1);
        expect_m("t1_110", 16'd110, 3, 1'b1);
        expect_m("t1_120", 16'd120, 3, 1'b1);
        expect_m("t1_130", 16'd130, 3, 1'b1);
        expect_done("t1", 16'd130);

        // down sweep with clamp at the endpoint
        start_sweep(2'b00, 16'd50, 16'd20, 16'd15, 16'd1);
        expect_m("t2_50", 16'd50, 1, 1'b0);
        expect_m("t2_35", 16'd35, 1, 1'b0);
        expect_m("t2_20", 16'd20, 1, 1'b0);
        expect_done("t2a", 16'd20);
        start_sweep(2'b00, 16'd0, 16'd25, 16'd10, 16'd1);
        expect_m("t2_0", 16'd0, 1, 1'b1);
        expect_m("t2_10", 16'd10, 1, 1'b1);
        expect_m("t2_20u", 16'd20, 1, 1'b1);
        expect_m("t2_25", 16'd25, 1, 1'b1);
        expect_done("t2b", 16'd25);

        // sawtooth near the top of the range: clamps to FFFF, never wraps
        start_sweep(2'b01, 16'hFFF0, 16'hFFFF, 16'd8, 16'd2);
        for (int k = 0; k < 2; k++) begin
            expect_m("t3_fff0", 16'hFFF0, 2, 1'b1);
            expect_m("t3_fff8", 16'hFFF8, 2, 1'b1);
            expect_m("t3_ffff", 16'hFFFF, 2, 1'b1);
        end
        expect_m("t3_fff0b", 16'hFFF0, 2, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_stop_busy", 32'(busy), 32'd0);
        chk("t3_stop_M", 32'(M), 32'hFFF8);
        chk("t3_stop_stb", 32'(step_stb), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t3_idle_stop_M", 32'(M), 32'hFFF8);
        chk("t3_idle_stop_busy", 32'(busy), 32'd0);

        // zero step and zero dwell behave as 1; mode 11 is single
        start_sweep(2'b11, 16'd5, 16'd8, 16'd0, 16'd0);
        expect_m("t3_5", 16'd5, 1, 1'b1);
        expect_m("t3_6", 16'd6, 1, 1'b1);
        expect_m("t3_7", 16'd7, 1, 1'b1);
        expect_m("t3_8", 16'd8, 1, 1'b1);
        expect_done("t3c", 16'd8);

        // triangle
        start_sweep(2'b10, 16'd0, 16'd20, 16'd10, 16'd1);
        expect_m("t4_0", 16'd0, 1, 1'b1);
        expect_m("t4_10", 16'd10, 1, 1'b1);
        expect_m("t4_20", 16'd20, 1, 1'b1);
        expect_m("t4_10d", 16'd10, 1, 1'b0);
        expect_m("t4_0d", 16'd0, 1, 1'b0);
        expect_m("t4_10u", 16'd10, 1, 1'b1);
        expect_m("t4_20u", 16'd20, 1, 1'b1);
        chk("t4_next_M", 32'(M), 32'd10);
        chk("t4_next_dir", 32'(dir_up), 32'd0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t4_stop_busy", 32'(busy), 32'd0);

        // stop during the second dwell cycle of 110
        start_sweep(2'b00, 16'd100, 16'd130, 16'd10, 16'd3);
        expect_m("t5_100", 16'd100, 3, 1'b1);
        expect_m("t5_110", 16'd110, 1, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("t5_stop_busy", 32'(busy), 32'd0);
        chk("t5_stop_M", 32'(M), 32'd110);
        chk("t5_stop_done", 32'(done), 32'd0);
        tick();
        chk("t5_hold_M", 32'(M), 32'd110);
        chk("t5_hold_done", 32'(done), 32'd0);

        // start and stop together in RUN
        start_sweep(2'b01, 16'd40, 16'd80, 16'd10, 16'd1);
        f_start = 16'd300;
        start   = 1'b1;
        stop    = 1'b1;
        tick();
        start   = 1'b0;
        stop    = 1'b0;
        chk("t5_ss_busy", 32'(busy), 32'd0);
        chk("t5_ss_M", 32'(M), 32'd40);
        tick();
        chk("t5_ss_busy2", 32'(busy), 32'd0);

        // start while busy is ignored
        start_sweep(2'b00, 16'd100, 16'd130, 16'd10, 16'd3);
        f_start = 16'd500;
        mode    = 2'b01;
        start   = 1'b1;
        expect_m("t5_ign_a", 16'd100, 1, 1'b1);
        start   = 1'b0;
        chk("t5_ign_M", 32'(M), 32'd100);
        chk("t5_ign_stb", 32'(step_stb), 32'd0);
        tick();
        tick();
        expect_m("t5_ign_110", 16'd110, 1, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // asynchronous reset mid-sweep
        start_sweep(2'b00, 16'd50, 16'd20, 16'd15, 16'd2);
        tick();
        chk("t6_pre_dir", 32'(dir_up), 32'd0);
        rst = 1'b0;
        #1;
        chk("t6_rst_M", 32'(M), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_dir", 32'(dir_up), 32'd1);
        chk("t6_rst_stb", 32'(step_stb), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        start_sweep(2'b00, 16'd100, 16'd130, 16'd10, 16'd3);
        expect_m("t6_100", 16'd100, 3, 1'b1);
        expect_m("t6_110", 16'd110, 1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
